// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between N_REQ register writers and the shared-register arbiter.
// Requesters drive req/lock/wdata; the arbiter returns the register view and grant status.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [WIDTH-1:0]       data_out;
    logic [N_REQ-1:0]       ack;
    logic [IDX_W-1:0]       owner;
    logic                   locked;
    logic                   timeout;

    modport master (
        output req, lock, wdata,
        input  data_out, ack, owner, locked, timeout
    );

    modport slave (
        input  req, lock, wdata,
        output data_out, ack, owner, locked, timeout
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one write per cycle into a shared register, with owner lock and idle timeout.
// Latency: request sampled at edge k, data_out/ack/owner valid right after edge k.
// Backpressure: a requester holds req until acked; dropping req earlier leaves no trace.
module reg_write_arbiter #(
    parameter int WIDTH    = 32,
    parameter int N_REQ    = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    reg_write_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("reg_write_arbiter: N_REQ must be in 2..8");
        end
        if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_lock_max
            $error("reg_write_arbiter: LOCK_MAX must be in 1..255");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] idle_cnt;
    logic [WIDTH-1:0] data_q;
    logic [N_REQ-1:0] ack_q;
    logic [IDX_W-1:0] owner_q;
    logic             locked_q;
    logic             timeout_q;

    // Round-robin search: scan offsets high to low so the lowest offset from ptr wins.
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (bus.req[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    logic [IDX_W-1:0] ptr_nxt;
    logic [WIDTH-1:0] win_dat;
    logic [WIDTH-1:0] own_dat;
    logic             own_req;
    logic             own_lock;
    logic [CNT_W-1:0] idle_cnt_nxt;

    assign ptr_nxt      = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    assign win_dat      = bus.wdata[win_idx*WIDTH +: WIDTH];
    assign own_dat      = bus.wdata[owner_q*WIDTH +: WIDTH];
    assign own_req      = bus.req[owner_q];
    assign own_lock     = bus.lock[owner_q];
    assign idle_cnt_nxt = idle_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idle_cnt  <= '0;
            data_q    <= '0;
            ack_q     <= '0;
            owner_q   <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (win_vld) begin
                        data_q  <= win_dat;
                        ack_q   <= N_REQ'(1) << win_idx;
                        owner_q <= win_idx;
                        ptr     <= ptr_nxt;
                        if (bus.lock[win_idx]) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Only the holder is visible here; ptr stays where the lock grant left it.
                    if (own_req) begin
                        data_q   <= own_dat;
                        ack_q    <= N_REQ'(1) << owner_q;
                        idle_cnt <= '0;
                        if (!own_lock) begin
                            state    <= IDLE;
                            locked_q <= 1'b0;
                        end
                    end else if (!own_lock) begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                        idle_cnt <= '0;
                    end else if (idle_cnt_nxt == CNT_MAX) begin
                        state     <= IDLE;
                        locked_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt_nxt;
                    end
                end
                default: begin
                    state    <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = data_q;
    assign bus.ack      = ack_q;
    assign bus.owner    = owner_q;
    assign bus.locked   = locked_q;
    assign bus.timeout  = timeout_q;
endmodule
